// File: rtl/fcounter_core.sv
// Count-up stopwatch core: 10 ms prescaler, packed-BCD min:sec:hundredths cascade, sticky limit flag.
// Optional lap hold registers are built when FCOUNTER_LAP_EN is defined.
module fcounter_core #(
    parameter int unsigned TICK_DIV = 1_000_000
) (
    input  logic       clk_core,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] min_i,
    input  logic [7:0] sec_i,
    input  logic [7:0] ms_10_i,
    input  logic       lap,
    output logic [7:0] min_o,
    output logic [7:0] sec_o,
    output logic [7:0] ms_10_o,
    output logic       time_out
);

    localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [7:0]    min_q, min_d;
    logic [7:0]    sec_q, sec_d;
    logic [7:0]    ms_q, ms_d;
    logic          time_out_q, time_out_d;

    logic running;
    logic tick;
    logic ms_lo_wrap, ms_wrap;
    logic sec_lo_wrap, sec_wrap;
    logic min_lo_wrap;

    always_comb begin
        running = en && !time_out_q;
        tick    = running && (presc_q == PRESC_MAX);

        presc_d = presc_q;
        if (running) begin
            presc_d = tick ? '0 : presc_q + 1'b1;
        end

        ms_lo_wrap  = (ms_q[3:0] == 4'd9);
        ms_wrap     = ms_lo_wrap && (ms_q[7:4] == 4'd9);
        sec_lo_wrap = (sec_q[3:0] == 4'd9);
        sec_wrap    = sec_lo_wrap && (sec_q[7:4] == 4'd5);
        min_lo_wrap = (min_q[3:0] == 4'd9);

        min_d = min_q;
        sec_d = sec_q;
        ms_d  = ms_q;
        if (tick) begin
            ms_d[3:0] = ms_lo_wrap ? 4'd0 : ms_q[3:0] + 4'd1;
            if (ms_lo_wrap) begin
                ms_d[7:4] = ms_wrap ? 4'd0 : ms_q[7:4] + 4'd1;
            end
            if (ms_wrap) begin
                sec_d[3:0] = sec_lo_wrap ? 4'd0 : sec_q[3:0] + 4'd1;
                if (sec_lo_wrap) begin
                    sec_d[7:4] = sec_wrap ? 4'd0 : sec_q[7:4] + 4'd1;
                end
            end
            // 99:59:99 rolls over silently; only the limit compare raises the flag
            if (ms_wrap && sec_wrap) begin
                min_d[3:0] = min_lo_wrap ? 4'd0 : min_q[3:0] + 4'd1;
                if (min_lo_wrap) begin
                    min_d[7:4] = (min_q[7:4] == 4'd9) ? 4'd0 : min_q[7:4] + 4'd1;
                end
            end
        end

        // Compare the next count so the flag rises on the same edge the count reaches the limit
        time_out_d = time_out_q;
        if (running && ({min_d, sec_d, ms_d} == {min_i, sec_i, ms_10_i})) begin
            time_out_d = 1'b1;
        end
    end

    always_ff @(posedge clk_core) begin
        if (rst) begin
            presc_q    <= '0;
            min_q      <= '0;
            sec_q      <= '0;
            ms_q       <= '0;
            time_out_q <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            min_q      <= min_d;
            sec_q      <= sec_d;
            ms_q       <= ms_d;
            time_out_q <= time_out_d;
        end
    end

    assign time_out = time_out_q;

`ifdef FCOUNTER_LAP_EN
    logic       hold_q, hold_d;
    logic [7:0] hmin_q, hmin_d;
    logic [7:0] hsec_q, hsec_d;
    logic [7:0] hms_q, hms_d;

    always_comb begin
        hold_d = hold_q;
        hmin_d = hmin_q;
        hsec_d = hsec_q;
        hms_d  = hms_q;
        if (lap) begin
            hold_d = !hold_q;
            if (!hold_q) begin
                hmin_d = min_q;
                hsec_d = sec_q;
                hms_d  = ms_q;
            end
        end
    end

    always_ff @(posedge clk_core) begin
        if (rst) begin
            hold_q <= 1'b0;
            hmin_q <= '0;
            hsec_q <= '0;
            hms_q  <= '0;
        end else begin
            hold_q <= hold_d;
            hmin_q <= hmin_d;
            hsec_q <= hsec_d;
            hms_q  <= hms_d;
        end
    end

    always_comb begin
        min_o   = hold_q ? hmin_q : min_q;
        sec_o   = hold_q ? hsec_q : sec_q;
        ms_10_o = hold_q ? hms_q  : ms_q;
    end
`else
    logic unused_lap;
    assign unused_lap = lap;

    always_comb begin
        min_o   = min_q;
        sec_o   = sec_q;
        ms_10_o = ms_q;
    end
`endif

endmodule

// File: doc/fcounter_core.md
# fcounter_core

Count-up (stopwatch) timing core: the forward-direction counterpart of the countdown core driven by the timer commander. It divides `clk_core` down to a 10 ms tick and advances a packed-BCD min:sec:10ms count from 00:00:00 toward a commander-supplied limit. It raises `time_out` when the limit is reached. The commander owns the buttons and display muxing; this block owns time.

## Interface
- `TICK_DIV`, default 1_000_000: `clk_core` cycles per 10 ms tick (100 MHz clock). Legal range ≥ 2.
- `clk_core` in 1: core clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `en` in 1: count enable; 0 pauses with all state held.
- `min_i` in 8: limit minutes, packed BCD 00–99.
- `sec_i` in 8: limit seconds, packed BCD 00–59.
- `ms_10_i` in 8: limit hundredths, packed BCD 00–99.
- `lap` in 1: single-cycle lap request (see Configuration).
- `min_o` out 8: displayed minutes, packed BCD.
- `sec_o` out 8: displayed seconds, packed BCD.
- `ms_10_o` out 8: displayed hundredths, packed BCD.
- `time_out` out 1: sticky flag, set when the count equals the limit.

## Operation
- Reset behaviour: count = 00:00:00, prescaler = 0, `time_out` = 0, lap hold released, and all outputs 0.
- Prescaler:
  - Counts 0..TICK_DIV-1 while `en`=1 and `time_out`=0; otherwise it holds.
  - A tick occurs in the cycle where the prescaler is at TICK_DIV-1 and is counting. The prescaler then returns to 0.
- BCD cascade on each tick:
  - ms_10 low digit 0–9; a carry moves into the high digit 0–9.
  - ms_10 99→00 carries into sec; sec low digit 0–9, high digit 0–5.
  - sec 59→00 carries into min; min runs 00–99.
  - 99:59:99 wraps to 00:00:00 with no flag.
- Limit compare:
  - `time_out` is set on the clock edge where the next count equals {min_i,sec_i,ms_10_i}.
  - Once `time_out`=1, counting stops and the count stays at the limit until `rst`.
  - Limit inputs are sampled every cycle and may change while counting.
  - If the limit is moved below the current count, counting continues through the wrap until it matches.
  - A non-BCD or out-of-range limit (e.g. sec 0x60) never matches, so the block free-runs and wraps.
- Zero limit: with limit 00:00:00, `time_out` sets on the first cycle `en`=1 after reset and the count stays 00:00:00.
- Priority: `rst` > `time_out` stop > `en`. When `en` falls in the same cycle as a would-be tick, no increment occurs.

## Timing
- All outputs are registered; there are no combinational paths from input to output.
- Tick-to-display latency is 0: `*_o` shows the new count in the same cycle the count registers update.
- With `en` held high from reset release, the first increment (00:00:01) is visible TICK_DIV cycles after `rst` falls.
- `time_out` rises on the same edge that the count registers take the limit value.
- Pausing and resuming is exact: the prescaler phase is held, so no partial ticks are lost or gained.

## Configuration
- `FCOUNTER_LAP_EN` defined:
  - A `lap` pulse while no hold is active latches the current count into hold registers on that edge.
  - While the hold is active, `*_o` drive the held value and the internal count keeps running.
  - The next `lap` pulse releases the hold; `*_o` show the live count from the following cycle.
  - `rst` releases the hold.
  - `time_out` always reflects the live count, even while the hold is active.
- `FCOUNTER_LAP_EN` undefined: `lap` is ignored, no hold registers are built, and `*_o` always show the live count.

## Test plan
Run all scenarios with TICK_DIV=4.
- Reset: assert `rst` 3 cycles with `en`=1 -> all outputs 0x00 and `time_out`=0; the first increment to ms_10_o=0x01 appears 4 cycles after `rst` falls.
- Cascade: limit 99:59:99 + invalid (sec_i=0x60), run 6000 ticks -> outputs 01:00:00 (min_o=0x01, sec_o=0x00, ms_10_o=0x00). Check 0x09→0x10, 0x99→0x00 and sec 0x59→0x00 transitions.
- Limit hit: limit 00:01:50 -> `time_out` rises on the edge sec_o=0x01, ms_10_o=0x50; the count then stays frozen for 100 further cycles.
- Pause: drop `en` at prescaler phase 2 for 50 cycles, then raise it -> the next increment occurs exactly 2 cycles after `en` rises.
- Boundaries:
  - Limit 00:00:00 -> `time_out`=1 one edge after the first `en` cycle.
  - `rst` asserted mid-count at 00:00:37 -> next cycle shows 00:00:00 and `time_out`=0.
- Lap (with `FCOUNTER_LAP_EN`): `lap` at count 00:00:12 -> outputs hold 0x12 while the internal count reaches 00:00:20; a second `lap` -> the next cycle shows the live value 0x20.
